// File: rtl/w1_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : w1_encoder_if
// Purpose  : Stream bundle between the r1 coefficient source, the w1 encoder
//            and the SHAKE absorber.
// Ports    : sec_lvl          packing-mode select (sampled at polynomial start)
//            valid_i/ready_i  input beat handshake (ready_i driven by encoder)
//            di               four r1 lanes, lane 0 earliest
//            valid_o/ready_o  output word handshake (ready_o from absorber)
//            do_w, last_o     packed word and end-of-polynomial flag
//            err_o            sticky r1 range error
// Revision : 1.0  initial release
// ============================================================================
interface w1_encoder_if #(
  parameter int COEFF_W = 24,
  parameter int LANES   = 4,
  parameter int OUT_W   = 64
);
  logic [2:0]               sec_lvl;
  logic                     valid_i;
  logic                     ready_i;
  logic [LANES*COEFF_W-1:0] di;
  logic                     valid_o;
  logic                     ready_o;
  logic [OUT_W-1:0]         do_w;
  logic                     last_o;
  logic                     err_o;

  // Source/sink side
  modport master (
    output sec_lvl, valid_i, di, ready_o,
    input  ready_i, valid_o, do_w, last_o, err_o
  );

  // Encoder side
  modport slave (
    input  sec_lvl, valid_i, di, ready_o,
    output ready_i, valid_o, do_w, last_o, err_o
  );
endinterface
`default_nettype wire

// File: rtl/w1_encoder.sv
`default_nettype none
// ============================================================================
// Module   : w1_encoder
// Purpose  : SimpleBitPack of Dilithium w1 (r1) coefficients into 64-bit
//            words for the c~ SHAKE absorber. 6 bits/coeff for sec level 2,
//            4 bits/coeff otherwise. last_o flags each polynomial's last word.
// Ports    : clk   rising-edge clock
//            rst   synchronous active-high reset
//            bus   w1_encoder_if.slave (beat input, word output, err_o)
// Revision : 1.0  initial release
// ============================================================================
module w1_encoder #(
  parameter int COEFF_W = 24,
  parameter int LANES   = 4,
  parameter int OUT_W   = 64,
  parameter int BUF_W   = 128,
  parameter int N_COEFF = 256
) (
  input  logic        clk,
  input  logic        rst,
  w1_encoder_if.slave bus
);

  localparam int BEATS   = N_COEFF / LANES;
  localparam int BC_W    = $clog2(BEATS);
  localparam int WORDS_6 = N_COEFF * 6 / OUT_W;
  localparam int WORDS_4 = N_COEFF * 4 / OUT_W;
  localparam int WC_W    = $clog2(WORDS_6);
  localparam int FILL_W  = $clog2(BUF_W + 1);
  localparam int BEAT_W  = LANES * 6;
  localparam int MAX_6   = 43;
  localparam int MAX_4   = 15;
  localparam logic [2:0] LVL2_CODE = 3'b010;

  logic [BUF_W-1:0]  buf_q, buf_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [BC_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
  logic              mode6_q, mode6_d;   // packing mode of the current polynomial
  logic              hold_q, hold_d;     // all beats taken, waiting for last word
  logic              err_q, err_d;

  logic              beat_mode6;
  logic              pop, push, last_pop;
  logic [WC_W-1:0]   last_idx;
  logic [FILL_W-1:0] fill_s, beat_len;
  logic [BUF_W-1:0]  buf_s;
  logic [BEAT_W-1:0] beat6, beat_bits;
  logic [LANES*4-1:0] beat4;
  logic [LANES-1:0]  lane_bad;

  // The first beat of a polynomial takes its mode straight from sec_lvl;
  // later beats use the latched mode so mid-polynomial changes are ignored.
  assign beat_mode6 = (beat_cnt_q == '0) ? (bus.sec_lvl == LVL2_CODE) : mode6_q;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [COEFF_W-1:0] lane;
    assign lane            = bus.di[k*COEFF_W +: COEFF_W];
    assign beat6[k*6 +: 6] = lane[5:0];
    assign beat4[k*4 +: 4] = lane[3:0];
    assign lane_bad[k]     = beat_mode6 ? (lane > COEFF_W'(MAX_6))
                                        : (lane > COEFF_W'(MAX_4));
  end

  assign beat_bits = beat_mode6 ? beat6 : BEAT_W'(beat4);
  assign beat_len  = beat_mode6 ? FILL_W'(LANES * 6) : FILL_W'(LANES * 4);

  assign last_idx    = mode6_q ? WC_W'(WORDS_6 - 1) : WC_W'(WORDS_4 - 1);
  assign bus.valid_o = (fill_q >= FILL_W'(OUT_W));
  assign bus.do_w    = buf_q[OUT_W-1:0];
  assign bus.last_o  = bus.valid_o && (word_cnt_q == last_idx);
  assign bus.err_o   = err_q;

  assign pop      = bus.valid_o & bus.ready_o;
  assign last_pop = pop & bus.last_o;

  // Pop first, then append at the post-pop fill level.
  assign fill_s = pop ? (fill_q - FILL_W'(OUT_W)) : fill_q;
  assign buf_s  = pop ? (buf_q >> OUT_W) : buf_q;

  // A drained polynomial may hand over to the next one in the same cycle its
  // last word leaves, which keeps back-to-back polynomials bubble-free.
  assign bus.ready_i = !rst
                    && (({1'b0, fill_s} + {1'b0, beat_len}) <= (FILL_W + 1)'(BUF_W))
                    && (!hold_q || last_pop);

  assign push = bus.valid_i & bus.ready_i;

  always_comb begin
    buf_d      = buf_s;
    fill_d     = fill_s;
    beat_cnt_d = beat_cnt_q;
    word_cnt_d = word_cnt_q;
    mode6_d    = mode6_q;
    hold_d     = hold_q;
    err_d      = err_q;

    if (pop) begin
      word_cnt_d = last_pop ? '0 : (word_cnt_q + 1'b1);
    end
    if (last_pop) begin
      hold_d = 1'b0;
    end

    if (push) begin
      // Bits above fill are always zero, so OR-ing appends cleanly.
      buf_d      = buf_s | (BUF_W'(beat_bits) << fill_s);
      fill_d     = fill_s + beat_len;
      beat_cnt_d = beat_cnt_q + 1'b1;
      if (beat_cnt_q == '0) begin
        mode6_d = beat_mode6;
      end
      if (beat_cnt_q == BC_W'(BEATS - 1)) begin
        hold_d = 1'b1;
      end
      if (|lane_bad) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q      <= '0;
      fill_q     <= '0;
      beat_cnt_q <= '0;
      word_cnt_q <= '0;
      mode6_q    <= 1'b0;
      hold_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      buf_q      <= buf_d;
      fill_q     <= fill_d;
      beat_cnt_q <= beat_cnt_d;
      word_cnt_q <= word_cnt_d;
      mode6_q    <= mode6_d;
      hold_q     <= hold_d;
      err_q      <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_w1_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_w1_encoder
// Purpose  : Self-checking bench for w1_encoder: reset state, 6-bit and
//            4-bit packing, backpressure, back-to-back polynomials, random
//            handshakes, range errors and mid-polynomial reset.
// Ports    : none
// Revision : 1.0  initial release
// ============================================================================
module tb_w1_encoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  w1_encoder_if intf ();

  w1_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (intf)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] T1_WORD0 = 64'h3081_1030_8110_3081;
  localparam logic [63:0] T2_WORD  = 64'h4321_4321_4321_4321;

  logic [23:0] coef [0:3][0:255];
  bit          is6  [0:3];
  logic [63:0] got_w [0:127];
  bit          got_l [0:127];
  logic [63:0] exp_w [0:127];
  bit          exp_l [0:127];
  int n_got, n_exp;
  int stall_cnt, first_valid_cyc, hold_changed, ready_low_in_stall;
  bit timed_out;

  // Reference SimpleBitPack: bit g of a polynomial's stream is bit g%W of
  // coefficient g/W.
  function automatic void build_expected(input int npoly);
    int w;
    int nw;
    int g;
    logic [63:0] word;
    n_exp = 0;
    for (int p = 0; p < npoly; p++) begin
      w  = is6[p] ? 6 : 4;
      nw = 256 * w / 64;
      for (int j = 0; j < nw; j++) begin
        for (int k = 0; k < 64; k++) begin
          g = 64 * j + k;
          word[k] = coef[p][g / w][g % w];
        end
        exp_w[n_exp] = word;
        exp_l[n_exp] = (j == nw - 1);
        n_exp++;
      end
    end
  endfunction

  function automatic void fill_const(input int p, input bit six);
    is6[p] = six;
    for (int i = 0; i < 256; i++) coef[p][i] = 24'((i % 4) + 1);
  endfunction

  function automatic void fill_rand(input int p, input bit six);
    is6[p] = six;
    for (int i = 0; i < 256; i++) coef[p][i] = 24'($urandom_range(six ? 43 : 15));
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; intf.valid_i = 1'b0; intf.ready_o = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [95:0] d, input logic [2:0] s, input logic r);
    @(negedge clk);
    intf.valid_i = v; intf.di = d; intf.sec_lvl = s; intf.ready_o = r;
    @(posedge clk);
    #1;
  endtask

  // Streams npoly polynomials from coef[], collecting popped words.
  task automatic stream(input int npoly, input int vpct, input int rpct, input bit scramble,
                        input int stall_at, input int stall_len);
    int b = 0;
    int cyc = 0;
    int total = npoly * 64;
    bit in_stall;
    bit have_held = 0;
    logic [63:0] held = '0;
    n_got = 0; stall_cnt = 0; first_valid_cyc = -1;
    hold_changed = 0; ready_low_in_stall = 0; timed_out = 0;
    build_expected(npoly);
    while (n_got < n_exp) begin
      if (cyc >= 5000) begin timed_out = 1; break; end
      @(negedge clk);
      in_stall = (cyc >= stall_at) && (cyc < stall_at + stall_len);
      intf.valid_i = (b < total) && ($urandom_range(99) < vpct);
      if (b < total) begin
        for (int k = 0; k < 4; k++) intf.di[24*k +: 24] = coef[b / 64][(b % 64) * 4 + k];
        intf.sec_lvl = (scramble && (b % 64) != 0) ? 3'($urandom_range(7))
                                                   : (is6[b / 64] ? 3'b010 : 3'b011);
      end
      intf.ready_o = !in_stall && ($urandom_range(99) < rpct);
      #1;
      if (first_valid_cyc < 0 && intf.valid_o) first_valid_cyc = cyc;
      if (intf.valid_i && !intf.ready_i) stall_cnt++;
      if (in_stall) begin
        if (have_held && (!intf.valid_o || intf.do_w !== held)) hold_changed++;
        if (!have_held && intf.valid_o) begin held = intf.do_w; have_held = 1; end
        if (!intf.ready_i) ready_low_in_stall++;
      end
      if (intf.valid_i && intf.ready_i) b++;
      if (intf.valid_o && intf.ready_o) begin
        got_w[n_got] = intf.do_w; got_l[n_got] = intf.last_o; n_got++;
      end
      cyc++;
    end
    @(negedge clk);
    intf.valid_i = 1'b0; intf.ready_o = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    checks++; if (intf.ready_i !== 1'b0) begin errors++; $display("FAIL reset_ready_i got %b want 0", intf.ready_i); end
    checks++; if (intf.valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid_o got %b want 0", intf.valid_o); end
    checks++; if (intf.do_w !== 64'h0) begin errors++; $display("FAIL reset_do_w got %h want 0", intf.do_w); end
    checks++; if (intf.last_o !== 1'b0) begin errors++; $display("FAIL reset_last_o got %b want 0", intf.last_o); end
    checks++; if (intf.err_o !== 1'b0) begin errors++; $display("FAIL reset_err_o got %b want 0", intf.err_o); end
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (intf.ready_i !== 1'b1) begin errors++; $display("FAIL post_reset_ready_i got %b want 1", intf.ready_i); end
  endtask

  task automatic test_lvl2();
    fill_const(0, 1);
    stream(1, 100, 100, 0, -1, 0);
    checks++; if (timed_out) begin errors++; $display("FAIL t1_timeout got %0d words want %0d", n_got, n_exp); end
    checks++; if (got_w[0] !== T1_WORD0) begin errors++; $display("FAIL t1_word0 got %h want %h", got_w[0], T1_WORD0); end
    checks++; if (first_valid_cyc !== 3) begin errors++; $display("FAIL t1_latency got %0d want 3", first_valid_cyc); end
    checks++; if (stall_cnt !== 0) begin errors++; $display("FAIL t1_bubbles got %0d want 0", stall_cnt); end
    for (int i = 0; i < n_exp; i++) begin
      checks++; if (got_w[i] !== exp_w[i]) begin errors++; $display("FAIL t1_word[%0d] got %h want %h", i, got_w[i], exp_w[i]); end
      checks++; if (got_l[i] !== exp_l[i]) begin errors++; $display("FAIL t1_last[%0d] got %b want %b", i, got_l[i], exp_l[i]); end
    end
  endtask

  task automatic test_lvl4();
    fill_const(0, 0);
    stream(1, 100, 100, 0, -1, 0);
    checks++; if (timed_out) begin errors++; $display("FAIL t2_timeout got %0d words want 16", n_got); end
    checks++; if (first_valid_cyc !== 4) begin errors++; $display("FAIL t2_latency got %0d want 4", first_valid_cyc); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (got_w[i] !== T2_WORD) begin errors++; $display("FAIL t2_word[%0d] got %h want %h", i, got_w[i], T2_WORD); end
      checks++; if (got_l[i] !== (i == 15)) begin errors++; $display("FAIL t2_last[%0d] got %b want %b", i, got_l[i], (i == 15)); end
    end
  endtask

  task automatic test_backpressure();
    fill_const(0, 1);
    stream(1, 100, 100, 0, 20, 20);
    checks++; if (timed_out) begin errors++; $display("FAIL t3_timeout got %0d words want %0d", n_got, n_exp); end
    checks++; if (hold_changed !== 0) begin errors++; $display("FAIL t3_hold_stable got %0d changes want 0", hold_changed); end
    checks++; if (ready_low_in_stall == 0) begin errors++; $display("FAIL t3_ready_i_drop got %0d low cycles want >0", ready_low_in_stall); end
    for (int i = 0; i < n_exp; i++) begin
      checks++; if (got_w[i] !== exp_w[i] || got_l[i] !== exp_l[i]) begin
        errors++; $display("FAIL t3_word[%0d] got %h/%b want %h/%b", i, got_w[i], got_l[i], exp_w[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    fill_const(0, 1);
    fill_const(1, 0);
    stream(2, 100, 100, 0, -1, 0);
    checks++; if (timed_out) begin errors++; $display("FAIL b2b_timeout got %0d words want %0d", n_got, n_exp); end
    checks++; if (stall_cnt !== 0) begin errors++; $display("FAIL b2b_bubbles got %0d want 0", stall_cnt); end
    for (int i = 0; i < n_exp; i++) begin
      checks++; if (got_w[i] !== exp_w[i] || got_l[i] !== exp_l[i]) begin
        errors++; $display("FAIL b2b_word[%0d] got %h/%b want %h/%b", i, got_w[i], got_l[i], exp_w[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_random();
    int lasts = 0;
    fill_rand(0, 1);
    fill_rand(1, 0);
    fill_rand(2, 1);
    stream(3, 70, 60, 1, -1, 0);
    checks++; if (timed_out) begin errors++; $display("FAIL t4_timeout got %0d words want %0d", n_got, n_exp); end
    for (int i = 0; i < n_exp; i++) begin
      if (got_l[i]) lasts++;
      checks++; if (got_w[i] !== exp_w[i] || got_l[i] !== exp_l[i]) begin
        errors++; $display("FAIL t4_word[%0d] got %h/%b want %h/%b", i, got_w[i], got_l[i], exp_w[i], exp_l[i]);
      end
    end
    checks++; if (lasts !== 3) begin errors++; $display("FAIL t4_last_count got %0d want 3", lasts); end
  endtask

  task automatic test_err();
    do_reset();
    drive(1, {24'd0, 24'd0, 24'd0, 24'd43}, 3'b010, 0);
    checks++; if (intf.err_o !== 1'b0) begin errors++; $display("FAIL t5_lvl2_43 got %b want 0", intf.err_o); end
    drive(1, {24'd0, 24'd0, 24'd0, 24'd44}, 3'b010, 0);
    checks++; if (intf.err_o !== 1'b1) begin errors++; $display("FAIL t5_lvl2_44 got %b want 1", intf.err_o); end
    drive(1, {24'd4, 24'd3, 24'd2, 24'd1}, 3'b010, 0);
    drive(0, '0, 3'b010, 0);
    checks++; if (intf.err_o !== 1'b1) begin errors++; $display("FAIL t5_sticky got %b want 1", intf.err_o); end
    do_reset();
    #1;
    checks++; if (intf.err_o !== 1'b0) begin errors++; $display("FAIL t5_err_clear got %b want 0", intf.err_o); end
    drive(1, {24'd15, 24'd15, 24'd15, 24'd15}, 3'b011, 0);
    checks++; if (intf.err_o !== 1'b0) begin errors++; $display("FAIL t5_lvl4_15 got %b want 0", intf.err_o); end
    do_reset();
    drive(1, {24'd4, 24'd3, 24'd2, 24'd16}, 3'b011, 0);
    checks++; if (intf.err_o !== 1'b1) begin errors++; $display("FAIL t5_lvl4_16 got %b want 1", intf.err_o); end
    for (int i = 0; i < 3; i++) drive(1, {24'd4, 24'd3, 24'd2, 24'd1}, 3'b011, 0);
    checks++; if (intf.valid_o !== 1'b1) begin errors++; $display("FAIL t5_valid got %b want 1", intf.valid_o); end
    checks++; if (intf.do_w !== 64'h4321_4321_4321_4320) begin
      errors++; $display("FAIL t5_trunc_word got %h want %h", intf.do_w, 64'h4321_4321_4321_4320);
    end
    drive(0, '0, 3'b011, 0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 10; i++) drive(1, {24'd4, 24'd3, 24'd2, 24'd1}, 3'b010, 1);
    @(negedge clk);
    rst = 1'b1; intf.valid_i = 1'b0; intf.ready_o = 1'b0;
    @(posedge clk); #1;
    checks++; if (intf.valid_o !== 1'b0) begin errors++; $display("FAIL t6_valid_o got %b want 0", intf.valid_o); end
    checks++; if (intf.ready_i !== 1'b0) begin errors++; $display("FAIL t6_ready_i got %b want 0", intf.ready_i); end
    checks++; if (intf.do_w !== 64'h0) begin errors++; $display("FAIL t6_do_w got %h want 0", intf.do_w); end
    @(negedge clk);
    rst = 1'b0;
    fill_const(0, 1);
    stream(1, 100, 100, 0, -1, 0);
    checks++; if (timed_out || n_got !== 24) begin errors++; $display("FAIL t6_words got %0d want 24", n_got); end
    checks++; if (got_w[0] !== T1_WORD0) begin errors++; $display("FAIL t6_word0 got %h want %h", got_w[0], T1_WORD0); end
    for (int i = 0; i < 24; i++) begin
      checks++; if (got_l[i] !== (i == 23)) begin errors++; $display("FAIL t6_last[%0d] got %b want %b", i, got_l[i], (i == 23)); end
    end
  endtask

  initial begin
    intf.valid_i = 1'b0;
    intf.ready_o = 1'b0;
    intf.di      = '0;
    intf.sec_lvl = 3'b010;
    test_reset();
    test_lvl2();
    test_lvl4();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_err();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
